// File: rtl/btn_pulse_conditioner_if.sv
// Signal bundle between a button conditioner and its user: sampling tick and raw button
// in, debounced level and event pulses out.
interface btn_pulse_conditioner_if;
    logic sample_en;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output sample_en, btn_raw,
        input  btn_level, press_pulse, release_pulse, repeat_pulse, held
    );

    modport slave (
        input  sample_en, btn_raw,
        output btn_level, press_pulse, release_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/btn_pulse_conditioner.sv
// Push-button conditioner: synchroniser chain, tick-sampled debounce FSM, press/release
// pulses, long-press flag and auto-repeat pulses. One instance per button.
module btn_pulse_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int HOLD_TICKS     = 10,
    parameter int REPEAT_TICKS   = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    btn_pulse_conditioner_if.slave   bus
);
    localparam int CNT_MAX_A = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_TICKS) ? CNT_MAX_A : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_DEB_PRESS   = 3'd1;
    localparam logic [2:0] ST_PRESSED     = 3'd2;
    localparam logic [2:0] ST_HOLDING     = 3'd3;
    localparam logic [2:0] ST_DEB_RELEASE = 3'd4;

    // Synchroniser runs every clock, independent of the sampling tick.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   btn_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = bus.btn_raw;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign btn_s = sync_reg[SYNC_STAGES-1];

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             held_reg, held_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             repeat_reg, repeat_next;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        held_next    = held_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;
        if (bus.sample_en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_s) begin
                        state_next = ST_DEB_PRESS;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!btn_s) begin
                        state_next = ST_IDLE;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt_reg == DEB_LAST) begin
                        state_next = ST_PRESSED;
                        cnt_next   = CNT_ZERO;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_s) begin
                        state_next = ST_DEB_RELEASE;
                        cnt_next   = CNT_ONE;
                    end else if (cnt_reg == HOLD_LAST) begin
                        state_next  = ST_HOLDING;
                        cnt_next    = CNT_ZERO;
                        held_next   = 1'b1;
                        repeat_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_HOLDING: begin
                    if (!btn_s) begin
                        state_next = ST_DEB_RELEASE;
                        cnt_next   = CNT_ONE;
                    end else if (cnt_reg == REP_LAST) begin
                        cnt_next    = CNT_ZERO;
                        repeat_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_DEB_RELEASE: begin
                    // A bounce back high keeps the press but restarts long-press timing.
                    if (btn_s) begin
                        state_next = ST_PRESSED;
                        cnt_next   = CNT_ZERO;
                        held_next  = 1'b0;
                    end else if (cnt_reg == DEB_LAST) begin
                        state_next   = ST_IDLE;
                        cnt_next     = CNT_ZERO;
                        level_next   = 1'b0;
                        held_next    = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                    level_next = 1'b0;
                    held_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= '0;
            state_reg   <= ST_IDLE;
            cnt_reg     <= CNT_ZERO;
            level_reg   <= 1'b0;
            held_reg    <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            sync_reg    <= sync_next;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            held_reg    <= held_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    assign bus.btn_level     = level_reg;
    assign bus.press_pulse   = press_reg;
    assign bus.release_pulse = release_reg;
    assign bus.repeat_pulse  = repeat_reg;
    assign bus.held          = held_reg;
endmodule
